writeback_regfile_sp: RTL and testbench

Writeback stage directly downstream of the third decode pipeline register. Each cycle it consumes that register's write address, write enable, PC-load, stack-pointer control (SPR write/increment/decrement) and address-mux select, together with the execute-stage result. It commits the result to an 8-entry general register file, maintains the stack pointer and program counter, and supplies bypassed read data to decode and a selected memory address.

---
 rtl/writeback_regfile_sp.sv | 90 +++++++++
 tb/tb_writeback_regfile_sp.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/writeback_regfile_sp.sv
// Writeback stage: 8-entry register file with write-first bypass, stack pointer and
// program counter, plus the memory address select.
module writeback_regfile_sp #(
    parameter int unsigned         DATA_W   = 16,
    parameter logic [DATA_W-1:0]   SP_RESET = 16'hFFFF,
    parameter logic [DATA_W-1:0]   PC_RESET = 16'h0000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              HOLD_IN,
    input  logic [2:0]        writeAd_IN,
    input  logic              write_IN,
    input  logic              PC_load_IN,
    input  logic              SPR_w_IN,
    input  logic              SPR_i_IN,
    input  logic              SPR_d_IN,
    input  logic              ADR_MUX_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [2:0]        rdAdA_IN,
    input  logic [2:0]        rdAdB_IN,
    output logic [DATA_W-1:0] rdA_OUT,
    output logic [DATA_W-1:0] rdB_OUT,
    output logic [DATA_W-1:0] SP_OUT,
    output logic [DATA_W-1:0] PC_OUT,
    output logic [DATA_W-1:0] ADDR_OUT
);

    localparam logic [DATA_W-1:0] One = DATA_W'(1);

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              wr_en;

    // A held cycle neither writes nor bypasses.
    assign wr_en = write_IN & ~HOLD_IN;

    always_comb begin
        rdA_OUT = regs_q[rdAdA_IN];
        rdB_OUT = regs_q[rdAdB_IN];
        if (wr_en && (rdAdA_IN == writeAd_IN)) begin
            rdA_OUT = DATA_IN;
        end
        if (wr_en && (rdAdB_IN == writeAd_IN)) begin
            rdB_OUT = DATA_IN;
        end
    end

    always_comb begin
        sp_d = sp_q;
        if (!HOLD_IN) begin
            if (SPR_w_IN) begin
                sp_d = DATA_IN;
            end else if (SPR_i_IN && !SPR_d_IN) begin
                sp_d = sp_q + One;
            end else if (SPR_d_IN && !SPR_i_IN) begin
                sp_d = sp_q - One;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (!HOLD_IN) begin
            pc_d = PC_load_IN ? DATA_IN : pc_q + One;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            sp_q <= SP_RESET;
            pc_q <= PC_RESET;
        end else begin
            if (wr_en) begin
                regs_q[writeAd_IN] <= DATA_IN;
            end
            sp_q <= sp_d;
            pc_q <= pc_d;
        end
    end

    assign SP_OUT   = sp_q;
    assign PC_OUT   = pc_q;
    // Address uses the pre-update SP so a push/pop addresses the current top.
    assign ADDR_OUT = ADR_MUX_IN ? sp_q : DATA_IN;

endmodule

// File: tb/tb_writeback_regfile_sp.sv
// Directed, table-driven bench for writeback_regfile_sp; vectors carry hand-computed
// expectations for the combinational outputs and the current SP/PC state.
module tb_writeback_regfile_sp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, wr, pcl, sw, si, sd, amux;
    logic [2:0]  wad, ra, rb;
    logic [15:0] data;
    logic [15:0] rd_a, rd_b, sp, pc, addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_regfile_sp dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .HOLD_IN    (hold),
        .writeAd_IN (wad),
        .write_IN   (wr),
        .PC_load_IN (pcl),
        .SPR_w_IN   (sw),
        .SPR_i_IN   (si),
        .SPR_d_IN   (sd),
        .ADR_MUX_IN (amux),
        .DATA_IN    (data),
        .rdAdA_IN   (ra),
        .rdAdB_IN   (rb),
        .rdA_OUT    (rd_a),
        .rdB_OUT    (rd_b),
        .SP_OUT     (sp),
        .PC_OUT     (pc),
        .ADDR_OUT   (addr)
    );

    typedef struct {
        logic        hold, wr, pcl, sw, si, sd, amux;
        logic [2:0]  wad, ra, rb;
        logic [15:0] data;
        logic [15:0] ea, eb, esp, epc, eaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic h, input logic w, input logic [2:0] wa,
                                input logic pl, input logic spw, input logic spi,
                                input logic spd, input logic am, input logic [15:0] d,
                                input logic [2:0] a, input logic [2:0] b,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [15:0] esp, input logic [15:0] epc,
                                input logic [15:0] eaddr);
        vec_t v;
        v.hold = h;  v.wr = w;   v.wad = wa;  v.pcl = pl;  v.sw = spw;
        v.si = spi;  v.sd = spd; v.amux = am; v.data = d;  v.ra = a;  v.rb = b;
        v.ea = ea;   v.eb = eb;  v.esp = esp; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        hold = 0; wr = 0; wad = 0; pcl = 0; sw = 0; si = 0; sd = 0; amux = 0;
        data = 0; ra = 0; rb = 0;
    endtask

    initial begin
        //          h  w wad pl sw si sd am data      ra rb  rdA      rdB      SP       PC       ADDR
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h1111, 0, 7, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h1111));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 2, 3, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 4, 6, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'hFFFF));
        vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 16'h1234, 5, 4, 16'h1234, 16'h0000, 16'hFFFF, 16'h0003, 16'h1234));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 5, 5, 16'h1234, 16'h1234, 16'hFFFF, 16'h0004, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 0, 5, 16'h0000, 16'h1234, 16'hFFFF, 16'h0005, 16'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0007, 16'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0008, 16'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h0009, 16'h0100));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h000A, 16'hFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'hFFFF, 16'h0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100));
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 16'h2222, 2, 2, 16'h2222, 16'h2222, 16'h0100, 16'h0001, 16'h2222));
        // held cycle: write, SP inc and PC load must all be ignored, no bypass
        vecs.push_back(mk(1, 1, 2, 1, 0, 1, 0, 1, 16'h9999, 2, 5, 16'h2222, 16'h1234, 16'h0100, 16'h0002, 16'h0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 2, 0, 16'h2222, 16'h0000, 16'h0100, 16'h0002, 16'h0100));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 16'h00F0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h0003, 16'h00F0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0ABC, 0, 0, 16'h0000, 16'h0000, 16'h00F0, 16'h0004, 16'h0ABC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 16'h0ABC, 0, 0, 16'h0000, 16'h0000, 16'h00F0, 16'h0005, 16'h00F0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h00EF, 16'h0006, 16'h00EF));
        vecs.push_back(mk(0, 1, 7, 1, 0, 1, 0, 1, 16'h7777, 7, 7, 16'h7777, 16'h7777, 16'h00EF, 16'h0007, 16'h00EF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 7, 3, 16'h7777, 16'h0000, 16'h00F0, 16'h7777, 16'h00F0));

        // Reset for two edges with a write and SP increment pending.
        idle();
        rst_n = 0; wr = 1; wad = 3; data = 16'h0055; si = 1; ra = 0; rb = 1; amux = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset rdA", rd_a, 16'h0000);
        check("reset rdB", rd_b, 16'h0000);
        check("reset SP", sp, 16'hFFFF);
        check("reset PC", pc, 16'h0000);
        check("reset ADDR", addr, 16'hFFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = 1;
            hold = vecs[i].hold; wr = vecs[i].wr; wad = vecs[i].wad; pcl = vecs[i].pcl;
            sw = vecs[i].sw; si = vecs[i].si; sd = vecs[i].sd; amux = vecs[i].amux;
            data = vecs[i].data; ra = vecs[i].ra; rb = vecs[i].rb;
            #1;
            check($sformatf("v%0d rdA", i), rd_a, vecs[i].ea);
            check($sformatf("v%0d rdB", i), rd_b, vecs[i].eb);
            check($sformatf("v%0d SP", i), sp, vecs[i].esp);
            check($sformatf("v%0d PC", i), pc, vecs[i].epc);
            check($sformatf("v%0d ADDR", i), addr, vecs[i].eaddr);
        end

        // Mid-stream reset discards the in-flight write and clears all state.
        @(negedge clk);
        idle();
        rst_n = 0; wr = 1; wad = 1; data = 16'hDEAD; si = 1;
        @(negedge clk);
        idle();
        rst_n = 1; ra = 1; rb = 7; amux = 1;
        #1;
        check("midreset rdA", rd_a, 16'h0000);
        check("midreset rdB", rd_b, 16'h0000);
        check("midreset SP", sp, 16'hFFFF);
        check("midreset PC", pc, 16'h0000);
        @(negedge clk);
        #1;
        check("midreset PC step", pc, 16'h0001);
        check("midreset reg1", rd_a, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
